// File: rtl/shared_reg_arb_pkg.sv
// Shared types and constants for the shared-register arbiter.
// SHARED_REG_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
package shared_reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_w(N_REQ_DEF);

endpackage

// File: rtl/shared_reg_arb_pick.sv
// Combinational winner picker: round-robin from ptr, or fixed
// priority (lowest index) when SHARED_REG_ARB_FIXED_PRIO_EN is defined.
module shared_reg_arb_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             found
);

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IW'(i);
        found  = 1'b1;
      end
    end
  end
`else
  int j;

  // Walk the ring starting at ptr; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        winner = IW'(j);
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/shared_reg_arb.sv
// Arbitrated single-register write port shared by N_REQ requesters.
// SHARED_REG_ARB_FIXED_PRIO_EN: fixed priority, no rotating pointer.
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0] gnt,
  output logic [DW-1:0]    q,
  output logic             q_valid,
  output logic             busy
);

  localparam int IW = idx_w(N_REQ);

  state_t           state, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IW-1:0]    win, win_q, ptr_sel;
  logic             found, take, write;

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
  assign ptr_sel = '0;
`else
  logic [IW-1:0] ptr_q;
  assign ptr_sel = ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  shared_reg_arb_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_sel),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    state_d = state;
    gnt_d   = '0;
    take    = 1'b0;
    write   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_d[win] = 1'b1;
          take       = 1'b1;
        end
      end
      GRANT: begin
        state_d = IDLE;
        write   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      win_q   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      if (take) win_q <= win;
      // Data is taken at the end of GRANT, not at request time.
      if (write) begin
        q       <= wdata[int'(win_q)*DW +: DW];
        q_valid <= 1'b1;
      end
    end
  end

  assign busy = (state == GRANT);

endmodule
